// File: rtl/adder_share_pkg.sv
// Shared constants for the adder-sharing arbiter: datapath width and the
// one-bit result-buffer state encoding (the encoding is the rsp_valid register).
package adder_share_pkg;
    localparam int   ADD_W    = 16;
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;
endpackage

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle between the client datapaths and the arbiter.
// master = client side, slave = arbiter side.
interface adder_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import adder_share_pkg::*;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ADD_W-1:0] req_a;
    logic [NREQ*ADD_W-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [ADD_W-1:0]      rsp_sum;
    logic                  rsp_cout;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/han_carlson_adder.sv
// Unsigned Han-Carlson prefix adder without carry-in: Kogge-Stone prefix over
// the odd bit positions, then one extra level fills in the even positions.
module han_carlson_adder
    import adder_share_pkg::*;
(
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);
    localparam int LVLS = $clog2(ADD_W);

    logic [ADD_W-1:0] w_g0;
    logic [ADD_W-1:0] w_p0;
    logic [ADD_W-1:0] w_g;
    logic [ADD_W-1:0] w_p;
    logic [ADD_W-1:0] w_gn;
    logic [ADD_W-1:0] w_pn;
    logic [ADD_W-1:0] w_gc;

    // Prefix tree: odd positions reach span [i:0] after LVLS levels.
    always_comb begin
        w_g0 = a & b;
        w_p0 = a ^ b;
        w_g  = w_g0;
        w_p  = w_p0;
        w_gn = w_g0;
        w_pn = w_p0;
        for (int l = 0; l < LVLS; l++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = ((l == 0) ? 1 : (1 << l) + 1); i < ADD_W; i += 2) begin
                w_gn[i] = w_g[i] | (w_p[i] & w_g[i - (1 << l)]);
                w_pn[i] = w_p[i] & w_p[i - (1 << l)];
            end
            w_g = w_gn;
            w_p = w_pn;
        end
    end

    // Final level: each even position merges with its completed odd neighbour.
    always_comb begin
        w_gc    = w_g;
        w_gc[0] = w_g0[0];
        for (int i = 2; i < ADD_W; i += 2) begin
            w_gc[i] = w_g0[i] | (w_p0[i] & w_g[i-1]);
        end
    end

    // Sum bits use the carry into each position, which is the prefix below it.
    always_comb begin
        sum    = w_p0;
        sum[0] = w_p0[0];
        for (int i = 1; i < ADD_W; i++) begin
            sum[i] = w_p0[i] ^ w_gc[i-1];
        end
        cout = w_gc[ADD_W-1];
    end
endmodule

// File: rtl/rr_grant.sv
// Round-robin grant: first set request found searching circularly from ptr.
module rr_grant #(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);
    int             w_pos;
    logic [IDW-1:0] w_idx;
    logic           w_hit;

    // Walk the requesters from ptr; only the first hit is recorded.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_pos   = 0;
        w_idx   = '0;
        w_hit   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos        = int'(ptr) + k;
            w_idx        = IDW'((w_pos >= NREQ) ? (w_pos - NREQ) : w_pos);
            w_hit        = !any && req[w_idx];
            gnt[w_idx]   = gnt[w_idx] | w_hit;
            gnt_idx      = w_hit ? w_idx : gnt_idx;
            any          = any | w_hit;
        end
    end
endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one Han-Carlson adder among NREQ requesters through a round-robin
// grant and a one-entry result buffer that supports one addition per cycle.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adder_share_arbiter_if.slave bus
);
    logic                 r_state;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_id;
    logic [ADD_W-1:0]     r_op_a;
    logic [ADD_W-1:0]     r_op_b;

    logic                 w_free;
    logic                 w_accept;
    logic [NREQ-1:0]      w_gnt;
    logic [IDW-1:0]       w_gnt_idx;
    logic                 w_any;
    logic [IDW-1:0]       w_ptr_nxt;
    logic [ADD_W-1:0]     w_sel_a;
    logic [ADD_W-1:0]     w_sel_b;
    logic [ADD_W-1:0]     w_sum;
    logic                 w_cout;

    rr_grant #(.NREQ(NREQ)) u_rr_grant (
        .req     (bus.req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // rst_n gates the grant so nothing is offered while reset is held.
    assign w_free        = (r_state == ST_EMPTY) || bus.rsp_ready;
    assign w_accept      = w_any && w_free && rst_n;
    assign bus.req_ready = w_accept ? w_gnt : {NREQ{1'b0}};

    assign w_sel_a   = bus.req_a[int'(w_gnt_idx)*ADD_W +: ADD_W];
    assign w_sel_b   = bus.req_b[int'(w_gnt_idx)*ADD_W +: ADD_W];
    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ-1)) ? {IDW{1'b0}} : (w_gnt_idx + IDW'(1));

    // Result buffer FSM: accept overrides release, giving back-to-back throughput.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_ptr   <= {IDW{1'b0}};
            r_id    <= {IDW{1'b0}};
            r_op_a  <= {ADD_W{1'b0}};
            r_op_b  <= {ADD_W{1'b0}};
        end else if (w_accept) begin
            r_state <= ST_FULL;
            r_ptr   <= w_ptr_nxt;
            r_id    <= w_gnt_idx;
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
        end else if ((r_state == ST_FULL) && bus.rsp_ready) begin
            r_state <= ST_EMPTY;
            r_ptr   <= r_ptr;
            r_id    <= r_id;
            r_op_a  <= r_op_a;
            r_op_b  <= r_op_b;
        end else begin
            r_state <= r_state;
            r_ptr   <= r_ptr;
            r_id    <= r_id;
            r_op_a  <= r_op_a;
            r_op_b  <= r_op_b;
        end
    end

    han_carlson_adder u_adder (
        .a    (r_op_a),
        .b    (r_op_b),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign bus.rsp_valid = r_state;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_sum   = w_sum;
    assign bus.rsp_cout  = w_cout;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter; responses are checked by a monitor
// against a queue of hand-computed expected results.
module tb_adder_share_arbiter;
    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] rr_a   [4];
    logic [15:0] rr_b   [4];
    logic [15:0] rr_sum [4];
    logic        rr_c   [4];

    always #5 clk = ~clk;

    adder_share_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

    adder_share_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
    endtask

    task automatic push(input logic [1:0] id, input logic [15:0] s, input logic c);
        exp_t e;
        e.id   = id;
        e.sum  = s;
        e.cout = c;
        sb_q.push_back(e);
    endtask

    // Monitor: every completed response handshake pops one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got id %0d sum 0x%0h, want no response", bus.rsp_id, bus.rsp_sum);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_id",   32'(bus.rsp_id),   32'(e.id));
                chk("rsp_sum",  32'(bus.rsp_sum),  32'(e.sum));
                chk("rsp_cout", 32'(bus.rsp_cout), 32'(e.cout));
            end
        end
    end

    initial begin
        rr_a[0] = 16'h0001; rr_b[0] = 16'h0002; rr_sum[0] = 16'h0003; rr_c[0] = 1'b0;
        rr_a[1] = 16'h1111; rr_b[1] = 16'h2222; rr_sum[1] = 16'h3333; rr_c[1] = 1'b0;
        rr_a[2] = 16'hF000; rr_b[2] = 16'h1000; rr_sum[2] = 16'h0000; rr_c[2] = 1'b1;
        rr_a[3] = 16'h7FFF; rr_b[3] = 16'h0001; rr_sum[3] = 16'h8000; rr_c[3] = 1'b0;

        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        cyc();
        cyc();
        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_sum",   32'(bus.rsp_sum),   32'h0);
        chk("rst_rsp_cout",  32'(bus.rsp_cout),  32'h0);
        chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
        cyc();
        bus.req_valid = 4'b0000;
        rst_n         = 1'b1;

        // Single request from requester 2.
        cyc();
        set_req(2, 16'h1234, 16'h0F0F);
        bus.req_valid = 4'b0100;
        #3;
        chk("single_ready", 32'(bus.req_ready), 32'h4);
        push(2'd2, 16'h2143, 1'b0);
        cyc();
        bus.req_valid = 4'b0000;
        #3;
        chk("single_ready_drop", 32'(bus.req_ready), 32'h0);
        chk("single_valid",      32'(bus.rsp_valid), 32'h1);

        // Carry-out cases on requester 0, issued back to back.
        cyc();
        set_req(0, 16'hFFFF, 16'h0001);
        bus.req_valid = 4'b0001;
        #3;
        chk("carry1_ready", 32'(bus.req_ready), 32'h1);
        push(2'd0, 16'h0000, 1'b1);
        cyc();
        set_req(0, 16'h8000, 16'h8000);
        #3;
        chk("carry2_ready", 32'(bus.req_ready), 32'h1);
        push(2'd0, 16'h0000, 1'b1);

        // Requester 3 alone moves the pointer back to 0.
        cyc();
        set_req(3, 16'h00FF, 16'h0F01);
        bus.req_valid = 4'b1000;
        #3;
        chk("align_ready", 32'(bus.req_ready), 32'h8);
        push(2'd3, 16'h1000, 1'b0);

        // Round-robin with all four requesters valid.
        cyc();
        for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i]);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("rr_ready", 32'(bus.req_ready), 32'(1) << (k % 4));
            chk("rr_valid", 32'(bus.rsp_valid), 32'h1);
            push(2'(k % 4), rr_sum[k % 4], rr_c[k % 4]);
            cyc();
        end

        // Backpressure with requester 1 withdrawing while the buffer is full.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1101;
        for (int j = 0; j < 5; j++) begin
            #3;
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_id",    32'(bus.rsp_id),    32'h0);
            chk("bp_sum",   32'(bus.rsp_sum),   32'h0003);
            chk("bp_cout",  32'(bus.rsp_cout),  32'h0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        #3;
        chk("wd_ready", 32'(bus.req_ready), 32'h4);
        push(2'd2, 16'h0000, 1'b1);
        cyc();
        bus.req_valid = 4'b0000;
        cyc();
        #3;
        chk("idle_valid", 32'(bus.rsp_valid), 32'h0);

        // Reset while full: the pending result is discarded.
        cyc();
        bus.rsp_ready = 1'b0;
        set_req(2, 16'h0102, 16'h0304);
        bus.req_valid = 4'b0100;
        #3;
        chk("rm_ready", 32'(bus.req_ready), 32'h4);
        cyc();
        set_req(1, 16'hABCD, 16'h1111);
        set_req(3, 16'h9000, 16'h9000);
        bus.req_valid = 4'b1010;
        #1;
        chk("rm_full", 32'(bus.rsp_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rm_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rm_sum",   32'(bus.rsp_sum),   32'h0);
        chk("rm_cout",  32'(bus.rsp_cout),  32'h0);
        chk("rm_id",    32'(bus.rsp_id),    32'h0);
        chk("rm_ready", 32'(bus.req_ready), 32'h0);
        cyc();
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        #3;
        chk("rm_grant", 32'(bus.req_ready), 32'h2);
        push(2'd1, 16'hBCDE, 1'b0);
        cyc();
        bus.req_valid = 4'b0000;
        cyc();
        cyc();
        chk("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adder_share_arbiter.md
# adder_share_arbiter

Round-robin arbiter that shares one 16-bit Han-Carlson prefix adder between up to four requesters. Each requester presents an operand pair over a valid/ready handshake. The arbiter grants one requester per cycle and latches its operands into the adder's input registers. It returns the sum, carry-out and requester ID on a single valid/ready response port. The block sits between the client datapaths and the adder instance, so the client datapaths never drive the adder directly.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..4.
- `IDW`, 2: requester ID width, equal to clog2(`NREQ`), minimum 1.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input `NREQ`: per-requester request valid.
- `req_a` input `NREQ`*16: operand A, requester i in bits [16i+15:16i].
- `req_b` input `NREQ`*16: operand B, same packing as `req_a`.
- `req_ready` output `NREQ`: per-requester accept, one-hot or zero.
- `rsp_valid` output 1: result valid.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_id` output `IDW`: index of the requester that owns the result.
- `rsp_sum` output 16: a+b mod 2^16.
- `rsp_cout` output 1: carry-out of the addition.

## Operation
- **State.** One-entry result buffer with states EMPTY and FULL, encoded by the `rsp_valid` register. Other state:
  - round-robin pointer `ptr` (`IDW` bits);
  - operand registers `op_a` and `op_b`;
  - ID register.
- **Free condition.** `free` = EMPTY, or (FULL and `rsp_ready`).
- **Grant.** The lowest-index requester with `req_valid` set, searching circularly from `ptr`. `req_ready[g]` = `free` and the grant. All other `req_ready` bits are 0. When `free` is low, no requester is ready.
- **Accept.** A request is accepted when `req_valid[g]` and `req_ready[g]` are both high. On accept:
  - `op_a` ← `req_a[g]`, `op_b` ← `req_b[g]`, ID ← g;
  - state → FULL;
  - `ptr` ← (g+1) mod `NREQ`.
- **Pointer hold.** `ptr` is unchanged in any cycle with no accept.
- **Release.** If FULL, `rsp_ready` is high and nothing is accepted, the state goes to EMPTY. Operand registers hold their value.
- **Back-to-back.** If FULL, `rsp_ready` is high and a new request is accepted in the same cycle, the state stays FULL with the new operands. This gives full throughput: one addition per cycle.
- **Result path.** The adder is fed only from `op_a`/`op_b`. `rsp_sum` and `rsp_cout` come combinationally from the adder outputs; there is no output register.
- **Arithmetic.** Unsigned 16-bit. `rsp_cout` = bit 16 of the 17-bit sum. There is no carry-in.
- **Fairness.** A requester holding `req_valid` is granted within `NREQ` accepts.
- **Withdrawn requests.** A requester may drop `req_valid` before it is accepted. The block must not latch that request.
- **Response stability.** While FULL and `rsp_ready` is low, `rsp_id`, `rsp_sum` and `rsp_cout` must stay stable.
- **Reset mid-operation.** An asynchronous reset at any time discards a pending result without handshake. The result is lost.

## Timing
- **Reset values:**
  - `rsp_valid` = 0;
  - `ptr` = 0;
  - `op_a` = `op_b` = 0, so `rsp_sum` = 0 and `rsp_cout` = 0;
  - `rsp_id` = 0;
  - `req_ready` = 0 while `rst_n` is low.
- **Latency.** Accept at edge N gives `rsp_valid` high after edge N, i.e. the result is visible in the cycle following the accept.
- **Combinational paths:**
  - `req_ready` depends on `req_valid`, `rsp_ready` and state. This is a `rsp_ready` → `req_ready` path, and the team accepts it.
  - `rsp_sum` and `rsp_cout` depend only on registers.
- **Simultaneous requests.** All `NREQ` valid at once with `ptr` = k: the grant order is k, k+1, … across consecutive accepts.
- **Idle cycles.** No grant, no pointer movement.

## Structure
- **Package `adder_share_pkg`:**
  - localparam `ADD_W` = 16;
  - the state-encoding constants `ST_EMPTY` and `ST_FULL`.
- **Sub-module.** The adder is instantiated unchanged as `han_carlson_adder` (ports a, b, sum, cout).
- **Arbiter logic.** The round-robin grant is its own sub-module `rr_grant` with parameter `NREQ`. Its inputs are `req` and `ptr`; its outputs are one-hot `gnt`, `gnt_idx` and `any`.

## Test plan
- **Single request.** Reset, then requester 2 presents a=0x1234, b=0x0F0F with `rsp_ready`=1. Expect `req_ready`=0100 for one cycle. Next cycle: `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=0x2143, `rsp_cout`=0.
- **Carry-out.** Requester 0 presents a=0xFFFF, b=0x0001. Expect `rsp_sum`=0x0000 and `rsp_cout`=1. Repeat with 0x8000+0x8000, expecting sum 0x0000 and cout 1.
- **Round-robin.** All four requesters valid continuously with `rsp_ready`=1. Expect grant order 0,1,2,3,0,… and `rsp_valid` high every cycle, with `rsp_id` lagging the grant by one cycle.
- **Backpressure.** Hold `rsp_ready`=0 for 5 cycles while the buffer is FULL. Expect `req_ready`=0 and a stable response. Raise `rsp_ready`: a new accept happens in the same cycle.
- **Withdrawn request.** Requester 1 drops `req_valid` while the buffer is FULL. Release the buffer: requester 1 is not granted, and the next valid requester is.
- **Reset mid-operation.** Assert `rst_n`=0 while FULL. Expect `rsp_valid`=0, `rsp_sum`=0 and `ptr`=0 immediately. After release, the first grant goes to the lowest valid index.
